// File: rtl/uart_pkg.sv
// Purpose: shared UART constants, autobaud FSM encoding and sync-character definition.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DVSR_W   = 8;   // baud generator divisor width
  localparam int DVSR_RST = 53;  // 115200 baud at 100 MHz with 16x oversampling
  localparam int CNT_W    = 16;  // autobaud measurement counter width
  localparam int OSR_LOG2 = 4;   // 16 rx ticks per bit

  // 0x55 sent LSB first gives a falling edge at the start bit and at
  // data bits 1, 3, 5 and 7, i.e. every two bit periods.
  localparam logic [7:0] SYNC_CHAR  = 8'h55;
  localparam int         SYNC_FALLS = 4;  // falls after the start-bit edge

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_EDGE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_CALC      = 3'd4
  } ab_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for an asynchronous level input; resets to 1 (idle line).
// Latency: 2 clk from d to q.
// Backpressure: none.
// Ports: clk, reset (sync, active-high), d (async input), q (synchronized output).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/autobaud_ctrl.sv
// Purpose: owns the baud divisor; set by direct cfg write or by timing a 0x55 sync char on rx.
// Latency: cfg write -> dvsr next clk; 4th sync fall seen -> done/dvsr 2 clk later.
// Backpressure: busy/baud_hold high during detection; start/cfg_we ignored while busy, abort cancels.
// Ports: clk, reset; rx (async serial in); start/abort pulses; cfg_we/cfg_dvsr direct write;
//        dvsr (registered divisor), busy, baud_hold (=busy), done/err one-cycle result pulses.
module autobaud_ctrl #(
  parameter int DVSR_W   = uart_pkg::DVSR_W,
  parameter int CNT_W    = uart_pkg::CNT_W,
  parameter int OSR_LOG2 = uart_pkg::OSR_LOG2,
  parameter int DVSR_RST = uart_pkg::DVSR_RST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_we,
  input  logic [DVSR_W-1:0] cfg_dvsr,
  output logic [DVSR_W-1:0] dvsr,
  output logic              busy,
  output logic              baud_hold,
  output logic              done,
  output logic              err
);

  import uart_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   Q_ONE    = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   Q_MAX    = (CNT_W+1)'(2**DVSR_W);
  // Half of the 8-bit-period * oversampling divisor, for round-to-nearest.
  localparam logic [CNT_W:0]   Q_RND    = (CNT_W+1)'(2**(OSR_LOG2+2));
  localparam logic [2:0]       LAST_FC  = 3'(SYNC_FALLS-1);

  logic              rx_sync;
  logic              prev_q, prev_d;
  logic              fall;

  ab_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        fallcnt_q, fallcnt_d;
  logic [DVSR_W-1:0] dvsr_q, dvsr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W:0]    quo;

  sync_2ff u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_sync)
  );

  assign prev_d = rx_sync;
  assign fall   = prev_q & ~rx_sync;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fallcnt_d = fallcnt_q;
    dvsr_d    = dvsr_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    // N = cnt_q in CALC; 8 bit periods, each 2^OSR_LOG2 ticks of dvsr+1 clocks.
    quo       = ({1'b0, cnt_q} + Q_RND) >> (OSR_LOG2 + 3);

    case (state_q)
      ST_IDLE: begin
        // A direct write wins over a simultaneous start.
        if (cfg_we) begin
          dvsr_d = cfg_dvsr;
        end else if (start) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (rx_sync) begin
          state_d = ST_WAIT_EDGE;
        end
      end
      ST_WAIT_EDGE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (fall) begin
          cnt_d     = '0;
          fallcnt_d = '0;
          state_d   = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          // Counting on the 4th-fall cycle too makes cnt equal t4 - t0 in CALC.
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (fall) begin
            fallcnt_d = fallcnt_q + 3'd1;
          end
          if (fall && (fallcnt_q == LAST_FC)) begin
            state_d = ST_CALC;
          end else if (cnt_q == CNT_MAX) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_CALC: begin
        state_d = ST_IDLE;
        if (!abort) begin
          if ((quo >= Q_ONE) && (quo <= Q_MAX)) begin
            dvsr_d = DVSR_W'(quo - Q_ONE);
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fallcnt_q <= '0;
      dvsr_q    <= DVSR_W'(DVSR_RST);
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fallcnt_q <= fallcnt_d;
      dvsr_q    <= dvsr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign dvsr      = dvsr_q;
  assign busy      = (state_q != ST_IDLE);
  assign baud_hold = busy;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_autobaud_ctrl.sv
// Purpose: directed self-checking bench for autobaud_ctrl (default instance plus a
//          short-divide instance, OSR_LOG2=0, for the divisor upper range edge).
// Latency/backpressure: n/a.
module tb_autobaud_ctrl;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       start;
  logic       start_h;
  logic       abort;
  logic       cfg_we;
  logic [7:0] cfg_dvsr;

  logic [7:0] dvsr, dvsr_h;
  logic       busy, busy_h;
  logic       baud_hold, baud_hold_h;
  logic       done, done_h;
  logic       err, err_h;

  int n_tests;
  int n_fail;
  int cyc;
  int done_n, err_n, done_cyc, err_cyc, fall_cyc;
  int dvsr_at_done, busy_at_done;
  bit mon_hi;

  autobaud_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .start     (start),
    .abort     (abort),
    .cfg_we    (cfg_we),
    .cfg_dvsr  (cfg_dvsr),
    .dvsr      (dvsr),
    .busy      (busy),
    .baud_hold (baud_hold),
    .done      (done),
    .err       (err)
  );

  // q = (N + 4) >> 3 here, so the 256 limit is reached with short frames.
  autobaud_ctrl #(.OSR_LOG2(0)) dut_h (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .start     (start_h),
    .abort     (abort),
    .cfg_we    (cfg_we),
    .cfg_dvsr  (cfg_dvsr),
    .dvsr      (dvsr_h),
    .busy      (busy_h),
    .baud_hold (baud_hold_h),
    .done      (done_h),
    .err       (err_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    logic d, e;
    @(posedge clk);
    #1;
    cyc++;
    d = mon_hi ? done_h : done;
    e = mon_hi ? err_h : err;
    if (d) begin
      done_n++;
      done_cyc     = cyc;
      dvsr_at_done = mon_hi ? int'(dvsr_h) : int'(dvsr);
      busy_at_done = mon_hi ? int'(busy_h) : int'(busy);
    end
    if (e) begin
      err_n++;
      err_cyc = cyc;
    end
  endtask

  task automatic clr();
    done_n = 0; err_n = 0; done_cyc = 0; err_cyc = 0;
    dvsr_at_done = -1; busy_at_done = -1;
  endtask

  task automatic kick();
    clr();
    if (mon_hi) start_h = 1'b1; else start = 1'b1;
    step();
    start = 1'b0; start_h = 1'b0;
  endtask

  // Start bit plus 0x55 LSB first; the last data bit (the 4th fall after the
  // start edge) is cut short, and the line then idles.
  task automatic frame(input int bc);
    logic [7:0] sc;
    int n;
    sc = 8'h55;
    for (int b = 0; b < 9; b++) begin
      rx = (b == 0) ? 1'b0 : sc[b-1];
      if (b == 8) fall_cyc = cyc;
      n = (b == 8 && bc > 12) ? 12 : bc;
      repeat (n) step();
    end
    rx = 1'b1;
    repeat (12) step();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; mon_hi = 1'b0;
    rx = 1'b1; start = 1'b0; start_h = 1'b0; abort = 1'b0;
    cfg_we = 1'b0; cfg_dvsr = 8'd0;
    clr();

    // Reset
    reset = 1'b1;
    repeat (2) step();
    check("rst_dvsr", int'(dvsr), 53);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_hold", int'(baud_hold), 0);
    reset = 1'b0;
    step();

    // Direct write
    clr();
    cfg_we = 1'b1; cfg_dvsr = 8'd10;
    step();
    cfg_we = 1'b0;
    check("cfg_dvsr", int'(dvsr), 10);
    step();
    check("cfg_nodone", done_n, 0);

    // 864 clk/bit: N=6912, q=54
    kick();
    check("ab864_busy", int'(busy), 1);
    check("ab864_hold", int'(baud_hold), 1);
    frame(864);
    check("ab864_done", done_n, 1);
    check("ab864_err", err_n, 0);
    check("ab864_dvsr", dvsr_at_done, 53);
    check("ab864_busy_at_done", busy_at_done, 0);

    // 128 clk/bit: N=1024, q=8; done 4 clk after the rx fall is driven
    kick();
    frame(128);
    check("ab128_done", done_n, 1);
    check("ab128_dvsr", dvsr_at_done, 7);
    check("ab128_lat", done_cyc - fall_cyc, 4);

    // 8 clk/bit: N=64, q=1 -> lower range edge, dvsr=0
    kick();
    frame(8);
    check("ab8_done", done_n, 1);
    check("ab8_dvsr", int'(dvsr), 0);

    // 7 clk/bit: N=56, q=0 -> err
    kick();
    frame(7);
    check("ab7_err", err_n, 1);
    check("ab7_done", done_n, 0);
    check("ab7_dvsr", int'(dvsr), 0);

    // 4 clk/bit: N=32, q=0 -> err
    kick();
    frame(4);
    check("ab4_err", err_n, 1);
    check("ab4_dvsr", int'(dvsr), 0);
    check("ab4_idle", int'(busy), 0);

    // Abort mid-MEASURE with a cfg write attempted while busy
    kick();
    rx = 1'b0;
    repeat (128) step();
    rx = 1'b1;
    repeat (60) step();
    cfg_we = 1'b1; cfg_dvsr = 8'd99;
    step();
    cfg_we = 1'b0;
    check("abort_cfg_ignored", int'(dvsr), 0);
    check("abort_busy_pre", int'(busy), 1);
    repeat (67) step();
    rx = 1'b0;
    repeat (20) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_dvsr", int'(dvsr), 0);
    rx = 1'b1;
    repeat (20) step();
    check("abort_done", done_n, 0);
    check("abort_err", err_n, 0);

    // start and cfg_we together in IDLE
    clr();
    start = 1'b1; cfg_we = 1'b1; cfg_dvsr = 8'd77;
    step();
    start = 1'b0; cfg_we = 1'b0;
    check("both_dvsr", int'(dvsr), 77);
    check("both_busy", int'(busy), 0);
    repeat (3) step();
    check("both_busy_later", int'(busy), 0);

    // Timeout: one fall then idle; cnt saturates 65535 clk after t0
    kick();
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (5) step();
    rx = 1'b1;
    for (int i = 0; i < 70000 && err_n == 0; i++) step();
    check("tmo_err", err_n, 1);
    check("tmo_lat", err_cyc - fall_cyc, 65539);
    check("tmo_done", done_n, 0);
    check("tmo_dvsr", int'(dvsr), 77);
    check("tmo_idle", int'(busy), 0);

    // Short-divide instance: it took cfg writes 10, 99, 77 while idle
    mon_hi = 1'b1;
    check("hi_dvsr_pre", int'(dvsr_h), 77);
    // 256 clk/bit: N=2048, q=(2048+4)>>3=256 -> dvsr=255
    kick();
    frame(256);
    check("hi256_done", done_n, 1);
    check("hi256_dvsr", dvsr_at_done, 255);
    // 257 clk/bit: N=2056, q=257 > 256 -> err
    kick();
    frame(257);
    check("hi257_err", err_n, 1);
    check("hi257_done", done_n, 0);
    check("hi257_dvsr", int'(dvsr_h), 255);
    check("hi_main_untouched", int'(dvsr), 77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
